// File: rtl/hack_scanline_fetcher.sv
// Scanline fetcher: bursts one Hack screen row per VGA line into a ping-pong
// line buffer and serialises the previously fetched row as a 1-bit pixel stream.
module hack_scanline_fetcher #(
   parameter logic [19:0] SCREEN_BASE     = 20'd16384,
   parameter int unsigned WORDS_PER_LINE  = 32,
   parameter int unsigned ROWS            = 256,
   parameter int unsigned H_OFFSET        = 64,
   parameter int unsigned V_OFFSET        = 112,
   parameter int unsigned MAX_OUTSTANDING = 4
) (
   input  logic        clk50,
   input  logic        reset,
   input  logic        pix_en,
   input  logic        line_start,
   input  logic        frame_start,
   input  logic [9:0]  vga_x,
   input  logic [9:0]  vga_y,
   output logic        mem_req,
   output logic [19:0] mem_addr,
   input  logic        mem_ready,
   input  logic        mem_rsp_valid,
   input  logic [15:0] mem_rsp_data,
   output logic        pixel,
   output logic        busy,
   output logic        underrun
);

   localparam int unsigned AW      = 20;
   localparam int unsigned DW      = 16;
   localparam int unsigned CW      = 11;
   localparam int unsigned JW      = $clog2(WORDS_PER_LINE);
   localparam int unsigned IW      = JW + 1;
   localparam int unsigned OW      = $clog2(MAX_OUTSTANDING + 1);
   localparam int unsigned RW      = $clog2(ROWS);
   localparam int unsigned LINE_PX = WORDS_PER_LINE * DW;

   typedef enum logic [1:0] {IDLE, REQ, DRAIN} state_t;

   state_t          state_q, state_d;
   logic [IW-1:0]   i_q, i_d;
   logic [JW-1:0]   j_q, j_d;
   logic [OW-1:0]   out_q, out_d;
   logic [RW-1:0]   row_q, row_d, pend_row_q, pend_row_d;
   logic            pend_q, pend_d;
   logic            front_sel_q, front_sel_d, front_v_q, front_v_d, back_v_q, back_v_d;
   logic            underrun_d, mem_req_d, pixel_d, busy_d;
   logic [AW-1:0]   mem_addr_d;
   logic            hs, rsp, launch_ok, start, buf_we;
   logic [CW-1:0]   n, h;
   logic [DW-1:0]   front_word;

   logic [DW-1:0]   line_buf [2][WORDS_PER_LINE];

   assign hs        = mem_req & mem_ready;
   assign rsp       = mem_rsp_valid && (state_q != IDLE) && (out_q != '0);
   assign n         = CW'({1'b0, vga_y}) + CW'(1) - CW'(V_OFFSET);
   assign launch_ok = line_start && !n[CW-1] && (n < CW'(ROWS));
   assign h         = CW'({1'b0, vga_x}) - CW'(H_OFFSET);
   assign front_word = line_buf[front_sel_q][h[JW+3:4]];

   // Next-state, buffer bookkeeping and registered-output values
   always_comb begin
      state_d     = state_q;
      i_d         = i_q + IW'(hs);
      j_d         = j_q + JW'(rsp);
      out_d       = out_q + OW'(hs) - OW'(rsp);
      row_d       = row_q;
      pend_d      = pend_q;
      pend_row_d  = pend_row_q;
      front_sel_d = front_sel_q;
      front_v_d   = front_v_q;
      back_v_d    = back_v_q;
      underrun_d  = underrun;
      mem_addr_d  = mem_addr;
      pixel_d     = pixel;
      buf_we      = 1'b0;
      start       = 1'b0;

      // frame_start wins; a coincident line_start only contributes its launch
      if (frame_start) begin
         front_v_d  = 1'b0;
         back_v_d   = 1'b0;
         underrun_d = 1'b0;
         pend_d     = 1'b0;
      end else if (line_start) begin
         if (back_v_q) begin
            front_sel_d = ~front_sel_q;
            front_v_d   = 1'b1;
            back_v_d    = 1'b0;
         end else begin
            front_v_d = 1'b0;
         end
      end
      if (launch_ok) begin
         pend_d     = 1'b1;
         pend_row_d = n[RW-1:0];
      end

      unique case (state_q)
         IDLE: start = pend_d;
         REQ: begin
            if (frame_start || line_start) begin
               state_d = DRAIN;
               if (!frame_start) underrun_d = 1'b1;
            end else if (rsp) begin
               buf_we = 1'b1;
               if (j_q == JW'(WORDS_PER_LINE - 1)) begin
                  back_v_d = 1'b1;
                  state_d  = IDLE;
               end
            end
         end
         DRAIN: begin
            if (out_q == '0) begin
               if (pend_d) start = 1'b1;
               else        state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase

      if (start) begin
         state_d = REQ;
         row_d   = pend_row_d;
         pend_d  = 1'b0;
         i_d     = '0;
         j_d     = '0;
      end

      mem_req_d = (state_d == REQ) && (i_d < IW'(WORDS_PER_LINE)) &&
                  (out_d < OW'(MAX_OUTSTANDING));
      if (mem_req_d)
         mem_addr_d = SCREEN_BASE + (AW'(row_d) << JW) + AW'(i_d);

      busy_d = (state_d != IDLE);

      if (pix_en)
         pixel_d = (h < CW'(LINE_PX)) && front_v_q && front_word[h[3:0]];
   end

   // State and output registers
   always_ff @(posedge clk50) begin
      if (reset) begin
         state_q     <= IDLE;
         i_q         <= '0;
         j_q         <= '0;
         out_q       <= '0;
         row_q       <= '0;
         pend_q      <= 1'b0;
         pend_row_q  <= '0;
         front_sel_q <= 1'b0;
         front_v_q   <= 1'b0;
         back_v_q    <= 1'b0;
         underrun    <= 1'b0;
         mem_req     <= 1'b0;
         mem_addr    <= '0;
         pixel       <= 1'b0;
         busy        <= 1'b0;
      end else begin
         state_q     <= state_d;
         i_q         <= i_d;
         j_q         <= j_d;
         out_q       <= out_d;
         row_q       <= row_d;
         pend_q      <= pend_d;
         pend_row_q  <= pend_row_d;
         front_sel_q <= front_sel_d;
         front_v_q   <= front_v_d;
         back_v_q    <= back_v_d;
         underrun    <= underrun_d;
         mem_req     <= mem_req_d;
         mem_addr    <= mem_addr_d;
         pixel       <= pixel_d;
         busy        <= busy_d;
      end
   end

   // Back buffer write port; validity is tracked separately so no reset needed
   always_ff @(posedge clk50) begin
      if (buf_we) line_buf[~front_sel_q][j_q] <= mem_rsp_data;
   end

endmodule

// File: tb/tb_hack_scanline_fetcher.sv
// Directed bench for hack_scanline_fetcher with an in-order SDRAM responder model.
module tb_hack_scanline_fetcher;

   logic        clk50, reset, pix_en, line_start, frame_start;
   logic [9:0]  vga_x, vga_y;
   logic        mem_req, mem_ready, mem_rsp_valid;
   logic [19:0] mem_addr;
   logic [15:0] mem_rsp_data;
   logic        pixel, busy, underrun;

   int checks = 0;
   int errors = 0;

   logic [15:0] mem [0:8191];
   logic [19:0] q[$];
   int          qt[$];
   logic [19:0] addr_log[$];
   int          cyc = 0;
   int          lat = 6;
   int          peak = 0;
   logic        rsp_hold = 1'b0;

   hack_scanline_fetcher dut (
      .clk50(clk50), .reset(reset), .pix_en(pix_en), .line_start(line_start),
      .frame_start(frame_start), .vga_x(vga_x), .vga_y(vga_y),
      .mem_req(mem_req), .mem_addr(mem_addr), .mem_ready(mem_ready),
      .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data),
      .pixel(pixel), .busy(busy), .underrun(underrun)
   );

   initial begin
      clk50 = 1'b0;
      forever #10 clk50 = ~clk50;
   end

   // Responder: answers accepted requests in order after lat cycles
   always @(negedge clk50) begin
      cyc = cyc + 1;
      mem_rsp_valid = 1'b0;
      if (!rsp_hold && q.size() > 0 && (cyc - qt[0]) >= lat) begin
         mem_rsp_valid = 1'b1;
         mem_rsp_data  = mem[13'(q[0] - 20'd16384)];
         void'(q.pop_front());
         void'(qt.pop_front());
      end
      if (mem_req && mem_ready) begin
         q.push_back(mem_addr);
         qt.push_back(cyc);
         addr_log.push_back(mem_addr);
      end
      if (q.size() > peak) peak = q.size();
   end

   task automatic tick();
      @(posedge clk50);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic pulse_line(input logic [9:0] y);
      line_start = 1'b1;
      vga_y = y;
      tick();
      line_start = 1'b0;
   endtask

   task automatic pix(input logic [9:0] x);
      pix_en = 1'b1;
      vga_x = x;
      tick();
      pix_en = 1'b0;
   endtask

   task automatic wait_idle(input int budget, input string tag);
      int k = 0;
      while (busy !== 1'b0 && k < budget) begin
         tick();
         k++;
      end
      check(tag, 32'(busy), 32'd0);
   endtask

   initial begin
      for (int k = 0; k < 8192; k++) mem[k] = 16'hFFFF;
      mem[0] = 16'h0001;
      mem[1] = 16'h8000;
      for (int k = 2; k < 32; k++) mem[k] = 16'h0000;
      mem_rsp_valid = 1'b0;
      mem_rsp_data  = '0;
      reset = 1'b1; pix_en = 1'b0; line_start = 1'b0; frame_start = 1'b0;
      vga_x = '0; vga_y = '0; mem_ready = 1'b1;
      repeat (3) tick();
      check("rst_mem_req", 32'(mem_req), 0);
      check("rst_mem_addr", 32'(mem_addr), 0);
      check("rst_pixel", 32'(pixel), 0);
      check("rst_busy", 32'(busy), 0);
      check("rst_underrun", 32'(underrun), 0);
      reset = 1'b0;
      tick();

      // Row 0 fetch, responder slow enough to saturate the outstanding limit
      peak = 0;
      addr_log.delete();
      pulse_line(10'd111);
      check("first_req", 32'(mem_req), 1);
      check("first_addr", 32'(mem_addr), 32'd16384);
      check("busy_fetch", 32'(busy), 1);
      wait_idle(400, "row0_done");
      check("row0_count", 32'(addr_log.size()), 32);
      for (int k = 0; k < 32; k++) check("row0_addr", 32'(addr_log[k]), 32'(16384 + k));
      check("peak_outstanding", 32'(peak), 4);

      // Display row 0
      lat = 2;
      pulse_line(10'd112);
      pix(10'd64);  check("pix_x64", 32'(pixel), 1);
      pix(10'd65);  check("pix_x65", 32'(pixel), 0);
      pix(10'd80);  check("pix_x80", 32'(pixel), 0);
      pix(10'd95);  check("pix_x95", 32'(pixel), 1);
      tick(); tick();
      check("pix_hold", 32'(pixel), 1);
      pix(10'd63);  check("pix_x63", 32'(pixel), 0);
      pix(10'd95);
      pix(10'd576); check("pix_x576", 32'(pixel), 0);
      wait_idle(400, "row1_done");

      // Underrun: fetch of row 2 stalls with 4 outstanding, next line aborts it
      rsp_hold = 1'b1;
      pulse_line(10'd113);
      repeat (10) tick();
      pulse_line(10'd114);
      check("abort_mem_req", 32'(mem_req), 0);
      check("abort_underrun", 32'(underrun), 1);
      repeat (5) tick();
      check("drain_busy", 32'(busy), 1);
      check("drain_mem_req", 32'(mem_req), 0);
      pix(10'd64);  check("underrun_black64", 32'(pixel), 0);
      pix(10'd100); check("underrun_black100", 32'(pixel), 0);
      rsp_hold = 1'b0;
      wait_idle(400, "row3_done");
      check("underrun_sticky", 32'(underrun), 1);
      frame_start = 1'b1;
      tick();
      frame_start = 1'b0;
      check("frame_clears_underrun", 32'(underrun), 0);

      // Vertical boundaries
      addr_log.delete();
      pulse_line(10'd367);
      repeat (5) tick();
      check("n256_no_req", 32'(addr_log.size()), 0);
      check("n256_busy", 32'(busy), 0);
      pulse_line(10'd366);
      check("row255_req", 32'(mem_req), 1);
      check("row255_addr", 32'(mem_addr), 32'd24544);
      wait_idle(400, "row255_done");
      check("row255_count", 32'(addr_log.size()), 32);
      check("row255_last", 32'(addr_log[31]), 32'd24575);

      // frame_start coincident with line_start during a fetch
      lat = 8;
      addr_log.delete();
      pulse_line(10'd200);
      pix(10'd64);  check("row255_pix", 32'(pixel), 1);
      for (int k = 0; k < 100 && addr_log.size() < 6; k++) tick();
      check("midfetch_reached", 32'(addr_log.size() >= 6), 1);
      frame_start = 1'b1;
      line_start = 1'b1;
      vga_y = 10'd111;
      tick();
      frame_start = 1'b0;
      line_start = 1'b0;
      addr_log.delete();
      check("coinc_mem_req", 32'(mem_req), 0);
      check("coinc_busy", 32'(busy), 1);
      check("coinc_underrun", 32'(underrun), 0);
      pix(10'd64);  check("coinc_front_invalid", 32'(pixel), 0);
      wait_idle(600, "coinc_done");
      check("coinc_count", 32'(addr_log.size()), 32);
      check("coinc_first", 32'(addr_log[0]), 32'd16384);
      check("coinc_underrun_end", 32'(underrun), 0);
      lat = 2;
      pulse_line(10'd112);
      pix(10'd64);  check("coinc_row0_pix64", 32'(pixel), 1);
      pix(10'd65);  check("coinc_row0_pix65", 32'(pixel), 0);
      wait_idle(400, "coinc_row1_done");

      // Reset during REQ with 3 outstanding
      rsp_hold = 1'b1;
      pulse_line(10'd111);
      for (int k = 0; k < 50 && q.size() < 3; k++) tick();
      check("three_outstanding", 32'(q.size()), 3);
      mem_ready = 1'b0;
      tick();
      reset = 1'b1;
      tick();
      check("mrst_mem_req", 32'(mem_req), 0);
      check("mrst_mem_addr", 32'(mem_addr), 0);
      check("mrst_busy", 32'(busy), 0);
      check("mrst_underrun", 32'(underrun), 0);
      check("mrst_pixel", 32'(pixel), 0);
      reset = 1'b0;
      rsp_hold = 1'b0;
      repeat (10) tick();
      check("stray_drained", 32'(q.size()), 0);
      check("stray_busy", 32'(busy), 0);
      check("stray_mem_req", 32'(mem_req), 0);
      check("stray_underrun", 32'(underrun), 0);
      pix(10'd64);  check("stray_pixel", 32'(pixel), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
